div_seq: RTL and testbench



---
 rtl/div_seq_pkg.sv | 30 +++
 rtl/div_seq_if.sv | 23 ++
 rtl/div_seq_step.sv | 26 ++
 rtl/div_seq.sv | 125 ++++++++++++
 tb/tb_div_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divide sequencer.
package div_seq_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // HI/LO payload: remainder in the upper word, quotient in the lower word.
  typedef struct packed {
    logic [RegBus-1:0] rem;
    logic [RegBus-1:0] quo;
  } div_result_t;

  // Conditional two's-complement negation, mod 2^RegBus.
  function automatic logic [RegBus-1:0] neg_if(input logic neg, input logic [RegBus-1:0] v);
    return neg ? (~v + RegBus'(1)) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider request/response bundle.
interface div_seq_if;
  import div_seq_pkg::*;

  logic              start_i;
  logic              signed_div_i;
  logic [RegBus-1:0] opdata1_i;
  logic [RegBus-1:0] opdata2_i;
  logic              annul_i;
  div_result_t       result_o;
  logic              ready_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring division step on the {rem, dividend} partial.
// The returned partial has bit 0 clear; the caller merges in qbit_o.
module div_seq_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W:0]  part_i,
  input  logic [W-1:0]  divisor_i,
  output logic [2*W:0]  part_o,
  output logic          qbit_o
);

  logic [2*W:0] shifted;
  logic [W+1:0] diff;

  // Shift left, trial-subtract from the upper W+1 bits, restore on borrow.
  always_comb begin
    shifted = part_i << 1;
    diff    = {1'b0, shifted[2*W:W]} - {2'b00, divisor_i};
    qbit_o  = ~diff[W+1];
    part_o  = shifted;
    if (qbit_o) begin
      part_o[2*W:W] = diff[W:0];
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: 32-step restoring divide with sign fix-up.
// Optional build macro DIV_ZERO_FAST_EN: zero divisor returns 0 after one cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DATA_W);
  localparam int unsigned PartW = 2 * DATA_W + 1;

  div_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PartW-1:0]  part_q, part_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  div_result_t       result_q, result_d;
  logic              ready_q, ready_d;

  logic              sign1, sign2;
  logic [PartW-1:0]  step_part;
  logic              step_qbit;

  div_seq_step #(.W(DATA_W)) u_div_step (
    .part_i    (part_q),
    .divisor_i (divisor_q),
    .part_o    (step_part),
    .qbit_o    (step_qbit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      part_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath logic; annul overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    sign1     = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    sign2     = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

    case (state_q)
      DivFree: begin
        if (bus.start_i == DivStart) begin
          part_d    = {(DATA_W + 1)'(0), neg_if(sign1, bus.opdata1_i)};
          divisor_d = neg_if(sign2, bus.opdata2_i);
          neg_quo_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
          state_d   = (bus.opdata2_i == '0) ? DivByZero : DivOn;
`else
          state_d   = DivOn;
`endif
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        part_d = step_part | PartW'(step_qbit);
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          result_d.quo = neg_if(neg_quo_q, part_d[DATA_W-1:0]);
          result_d.rem = neg_if(neg_rem_q, part_d[2*DATA_W-1:DATA_W]);
          ready_d      = DivResultReady;
          state_d      = DivEnd;
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end
      end
      default: begin
        state_d = DivFree;
      end
    endcase

    if (bus.annul_i) begin
      state_d  = DivFree;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = DivResultNotReady;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes expected {rem, quo} and ready cycle,
// a monitor thread pops on each rising ready_o.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_seq_if bus ();

  div_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_ZERO_FAST_EN
  localparam int          ZLAT  = 1;
  localparam logic [63:0] ZRES1 = 64'h0;
  localparam logic [63:0] ZRES2 = 64'h0;
`else
  localparam int          ZLAT  = 32;
  localparam logic [63:0] ZRES1 = 64'h0000000C_FFFFFFFF;
  localparam logic [63:0] ZRES2 = 64'hFFFFFFFB_00000001;
`endif

  typedef struct {
    logic [63:0] res;
    int          exp_cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.ready_o) begin
      errors++;
      $display("FAIL %s_timeout: ready_o got 0 expected 1 within 100 cycles", name);
    end
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input int hold);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    sb.push_back('{exp, cyc + 1 + lat, next_id});
    next_id++;
    @(negedge clk);
    bus.opdata1_i = a ^ 32'hA5A5_5A5A;
    bus.opdata2_i = b + 32'd3;
    bus.signed_div_i = ~sgn;
    wait_ready(name);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
      chk({name, "_hold_result"}, 64'(bus.result_o), exp);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    chk({name, "_release_ready"}, 64'(bus.ready_o), 64'd0);
    chk({name, "_release_result"}, 64'(bus.result_o), 64'd0);
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.annul_i      = 1'b0;

    fork
      begin : monitor
        exp_t e;
        logic ready_prev = 1'b0;
        forever begin
          @(negedge clk);
          if (bus.ready_o && !ready_prev) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ready: ready_o rose with empty scoreboard, result %h", bus.result_o);
            end else begin
              e = sb.pop_front();
              chk($sformatf("result_%0d", e.id), 64'(bus.result_o), e.res);
              chk($sformatf("latency_%0d", e.id), 64'(cyc), 64'(e.exp_cyc));
            end
          end
          ready_prev = bus.ready_o;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", 64'(bus.result_o), 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(DivFree));
    chk("reset_cnt", 64'(dut.cnt_q), 64'd0);
    rst = 1'b1;

    run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32, 3);
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32, 0);
    run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32, 0);
    run_div("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32, 0);
    run_div("divu_12_0",   1'b0, 32'd12,         32'd0,          ZRES1,                 ZLAT, 1);
    run_div("div_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          ZRES2,                 ZLAT, 0);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32, 0);
    run_div("divu_5_10",   1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 32, 0);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 32, 0);
    run_div("divu_big",    1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 32, 0);

    // Annul at iteration 10, then confirm nothing comes out.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_state", 64'(dut.state_q), 64'(DivFree));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("annul_quiet", 64'(bus.ready_o), 64'd0);
    end

    // Annul beats a same-edge start in IDLE.
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_vs_start_state", 64'(dut.state_q), 64'(DivFree));
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0);

    // Async reset mid-ON; start held over release begins a fresh divide.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", 64'(bus.result_o), 64'd0);
    chk("rst_on_state", 64'(dut.state_q), 64'(DivFree));
    chk("rst_on_cnt", 64'(dut.cnt_q), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{64'h00000002_0000000E, cyc + 1 + 32, next_id});
    next_id++;
    @(negedge clk);
    wait_ready("rst_restart");

    // Async reset while DONE drops the registered outputs without a clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_done_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_done_result", 64'(bus.result_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
